// File: rtl/frame_sequencer_pkg.sv
// Shared encodings and default widths for the frame animation sequencer.
package frame_sequencer_pkg;

    localparam int FRAME_BITS_DEF  = 2;
    localparam int DWELL_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_LOOP     = 2'd2,
        MODE_PINGPONG = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/frame_sequencer_dwell_timer.sv
// Counts scan wraps against a live dwell limit; o_expire strobes on the wrap
// that ends the current frame's dwell.
module dwell_timer
    import frame_sequencer_pkg::*;
#(
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_enable,
    input  logic                   i_scan_wrap,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    output logic                   o_expire
);

    logic [DWELL_WIDTH-1:0] r_cnt;
    logic                   w_tick;

    assign w_tick = i_enable & i_scan_wrap & ~i_clear;
    // >= rather than == so a dwell lowered below the count expires on the next wrap
    assign o_expire = w_tick && (r_cnt >= i_dwell);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            if (o_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Animates the charlieplex frame buffer: steps frame_index/mirror on scan
// boundaries in one-shot, loop or ping-pong order.
//   state   | meaning
//   ST_IDLE | static frame selection, waiting for start
//   ST_RUN  | sequencing frames on dwell expiry
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_scan_wrap,
    input  logic                   i_enable,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [1:0]             i_cfg_mode,
    input  logic [FRAME_BITS-1:0]  i_cfg_first_frame,
    input  logic [FRAME_BITS-1:0]  i_cfg_last_frame,
    input  logic [DWELL_WIDTH-1:0] i_cfg_dwell,
    input  logic                   i_cfg_mirror,
    input  logic                   i_cfg_mirror_toggle,
    output logic [FRAME_BITS-1:0]  o_frame_index,
    output logic                   o_is_mirror,
    output logic                   o_busy,
    output logic                   o_frame_advance,
    output logic                   o_done
);

    state_e                r_state;
    logic [FRAME_BITS-1:0] r_frame;
    logic                  r_mirror_phase;
    logic                  r_dir_down;
    logic                  r_busy;
    logic                  r_frame_advance;
    logic                  r_done;

    mode_e                 w_mode;
    logic                  w_expire;
    logic                  w_timer_clear;
    logic                  w_single;
    logic [FRAME_BITS-1:0] w_frame_inc;
    logic [FRAME_BITS-1:0] w_frame_dec;

    assign w_mode      = mode_e'(i_cfg_mode);
    assign w_single    = (i_cfg_first_frame == i_cfg_last_frame);
    assign w_frame_inc = r_frame + 1'b1;
    assign w_frame_dec = r_frame - 1'b1;

    // Any start/stop/mode-off discards a coincident scan wrap and restarts the dwell
    assign w_timer_clear = (r_state != ST_RUN) | i_start | i_stop | (w_mode == MODE_OFF);

    dwell_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_timer_clear),
        .i_enable    (i_enable),
        .i_scan_wrap (i_scan_wrap),
        .i_dwell     (i_cfg_dwell),
        .o_expire    (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_frame         <= '0;
            r_mirror_phase  <= 1'b0;
            r_dir_down      <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_advance <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_frame_advance <= 1'b0;
            r_done          <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_stop && (w_mode != MODE_OFF)) begin
                        r_state        <= ST_RUN;
                        r_frame        <= i_cfg_first_frame;
                        r_dir_down     <= 1'b0;
                        r_mirror_phase <= 1'b0;
                        r_busy         <= 1'b1;
                    end else if (w_mode == MODE_OFF) begin
                        r_frame <= i_cfg_first_frame;
                    end
                end
                ST_RUN: begin
                    if (i_stop || (w_mode == MODE_OFF)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_start) begin
                        r_frame        <= i_cfg_first_frame;
                        r_dir_down     <= 1'b0;
                        r_mirror_phase <= 1'b0;
                    end else if (w_expire) begin
                        case (w_mode)
                            MODE_ONESHOT: begin
                                if (r_frame != i_cfg_last_frame) begin
                                    r_frame         <= w_frame_inc;
                                    r_frame_advance <= 1'b1;
                                end else begin
                                    r_state <= ST_IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end
                            MODE_LOOP: begin
                                if (w_single) begin
                                    r_mirror_phase <= r_mirror_phase ^ i_cfg_mirror_toggle;
                                end else if (r_frame != i_cfg_last_frame) begin
                                    r_frame         <= w_frame_inc;
                                    r_frame_advance <= 1'b1;
                                end else begin
                                    r_frame         <= i_cfg_first_frame;
                                    r_frame_advance <= 1'b1;
                                    r_mirror_phase  <= r_mirror_phase ^ i_cfg_mirror_toggle;
                                end
                            end
                            MODE_PINGPONG: begin
                                if (w_single) begin
                                    r_mirror_phase <= r_mirror_phase ^ i_cfg_mirror_toggle;
                                end else if (!r_dir_down) begin
                                    r_frame_advance <= 1'b1;
                                    if (r_frame != i_cfg_last_frame) begin
                                        r_frame <= w_frame_inc;
                                    end else begin
                                        r_dir_down <= 1'b1;
                                        r_frame    <= w_frame_dec;
                                    end
                                end else begin
                                    r_frame_advance <= 1'b1;
                                    if (r_frame != i_cfg_first_frame) begin
                                        r_frame <= w_frame_dec;
                                    end else begin
                                        r_dir_down     <= 1'b0;
                                        r_frame        <= w_frame_inc;
                                        r_mirror_phase <= r_mirror_phase ^ i_cfg_mirror_toggle;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_frame_index   = r_frame;
    assign o_is_mirror     = i_cfg_mirror ^ r_mirror_phase;
    assign o_busy          = r_busy;
    assign o_frame_advance = r_frame_advance;
    assign o_done          = r_done;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed table-driven bench for frame_sequencer plus hand-written reset sequences.
module tb_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_wrap, enable, start, stop;
    logic [1:0] cfg_mode;
    logic [1:0] cfg_first, cfg_last;
    logic [7:0] cfg_dwell;
    logic       cfg_mirror, cfg_tog;
    logic [1:0] frame_index;
    logic       is_mirror, busy, frame_advance, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_sequencer #(.FRAME_BITS(2), .DWELL_WIDTH(8)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_scan_wrap         (scan_wrap),
        .i_enable            (enable),
        .i_start             (start),
        .i_stop              (stop),
        .i_cfg_mode          (cfg_mode),
        .i_cfg_first_frame   (cfg_first),
        .i_cfg_last_frame    (cfg_last),
        .i_cfg_dwell         (cfg_dwell),
        .i_cfg_mirror        (cfg_mirror),
        .i_cfg_mirror_toggle (cfg_tog),
        .o_frame_index       (frame_index),
        .o_is_mirror         (is_mirror),
        .o_busy              (busy),
        .o_frame_advance     (frame_advance),
        .o_done              (done)
    );

    typedef struct {
        logic [1:0] mode, first, last;
        logic [7:0] dwell;
        logic       mir, tog, en, start, stop, wrap;
        logic [1:0] e_frame;
        logic       e_busy, e_adv, e_done, e_mir;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] c_mode, c_first, c_last;
    logic [7:0] c_dwell;
    logic       c_mir, c_tog;

    task automatic cfg(input logic [1:0] m, f, l, input logic [7:0] d,
                       input logic mi, t);
        c_mode = m; c_first = f; c_last = l; c_dwell = d; c_mir = mi; c_tog = t;
    endtask

    task automatic add(input logic en, st, sp, wr, input logic [1:0] fr,
                       input logic bz, adv, dn, mr);
        vec_t v;
        v.mode = c_mode; v.first = c_first; v.last = c_last; v.dwell = c_dwell;
        v.mir = c_mir; v.tog = c_tog;
        v.en = en; v.start = st; v.stop = sp; v.wrap = wr;
        v.e_frame = fr; v.e_busy = bz; v.e_adv = adv; v.e_done = dn; v.e_mir = mr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int fr, bz, adv, dn, mr);
        chk({tag, " frame"}, int'(frame_index), fr);
        chk({tag, " busy"},  int'(busy), bz);
        chk({tag, " adv"},   int'(frame_advance), adv);
        chk({tag, " done"},  int'(done), dn);
        chk({tag, " mirror"}, int'(is_mirror), mr);
    endtask

    initial begin
        rst_n = 1'b0; scan_wrap = 0; enable = 1; start = 0; stop = 0;
        cfg_mode = 2'd0; cfg_first = 2'd0; cfg_last = 2'd0; cfg_dwell = 8'd0;
        cfg_mirror = 0; cfg_tog = 0;

        // reset state, then mode-off tracking and ignored start
        tick(); tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1; cfg_first = 2'd2;
        tick();
        chk_all("off_follow", 2, 0, 0, 0, 0);
        start = 1;
        tick();
        start = 0;
        chk_all("off_start_ignored", 2, 0, 0, 0, 0);

        // A: loop 0..3, dwell 1
        cfg(2'd2, 2'd0, 2'd3, 8'd1, 1'b0, 1'b0);
        add(1,1,0,0, 0,1,0,0,0);
        add(1,0,0,1, 0,1,0,0,0);
        add(1,0,0,0, 0,1,0,0,0);
        add(1,0,0,1, 1,1,1,0,0);
        add(1,0,0,0, 1,1,0,0,0);
        add(1,0,0,1, 1,1,0,0,0);
        add(1,0,0,1, 2,1,1,0,0);
        add(1,0,0,1, 2,1,0,0,0);
        add(1,0,0,1, 3,1,1,0,0);
        add(1,0,0,1, 3,1,0,0,0);
        add(1,0,0,1, 0,1,1,0,0);
        add(1,0,0,1, 0,1,0,0,0);
        add(1,0,0,1, 1,1,1,0,0);
        add(1,0,1,0, 1,0,0,0,0);
        // B: one-shot with wrapped range 3,0,1
        cfg(2'd1, 2'd3, 2'd1, 8'd0, 1'b0, 1'b0);
        add(1,1,0,0, 3,1,0,0,0);
        add(1,0,0,1, 0,1,1,0,0);
        add(1,0,0,1, 1,1,1,0,0);
        add(1,0,0,1, 1,0,0,1,0);
        add(1,0,0,0, 1,0,0,0,0);
        add(1,0,0,1, 1,0,0,0,0);
        // C: ping-pong 1..3 with mirror toggle at the bottom turn
        cfg(2'd3, 2'd1, 2'd3, 8'd0, 1'b0, 1'b1);
        add(1,1,0,0, 1,1,0,0,0);
        add(1,0,0,1, 2,1,1,0,0);
        add(1,0,0,1, 3,1,1,0,0);
        add(1,0,0,1, 2,1,1,0,0);
        add(1,0,0,1, 1,1,1,0,0);
        add(1,0,0,1, 2,1,1,0,1);
        add(1,0,0,1, 3,1,1,0,1);
        add(1,0,0,1, 2,1,1,0,1);
        add(1,1,0,0, 1,1,0,0,0);
        // D: priorities (stop over start, start discards scan wrap, mode-off as stop)
        add(1,1,1,0, 1,0,0,0,0);
        cfg(2'd2, 2'd1, 2'd3, 8'd2, 1'b0, 1'b0);
        add(1,1,0,0, 1,1,0,0,0);
        add(1,0,0,1, 1,1,0,0,0);
        add(1,0,0,1, 1,1,0,0,0);
        add(1,1,0,1, 1,1,0,0,0);
        add(1,0,0,1, 1,1,0,0,0);
        add(1,0,0,1, 1,1,0,0,0);
        add(1,0,0,1, 2,1,1,0,0);
        add(1,1,1,1, 2,0,0,0,0);
        add(1,1,0,0, 1,1,0,0,0);
        cfg(2'd0, 2'd2, 2'd3, 8'd2, 1'b0, 1'b0);
        add(1,0,0,1, 1,0,0,0,0);
        add(1,0,0,0, 2,0,0,0,0);
        // E: freeze with enable=0, resume remaining dwell, live dwell decrease
        cfg(2'd2, 2'd0, 2'd3, 8'd3, 1'b0, 1'b0);
        add(1,1,0,0, 0,1,0,0,0);
        add(1,0,0,1, 0,1,0,0,0);
        add(1,0,0,1, 0,1,0,0,0);
        for (int k = 0; k < 5; k++) add(0,0,0,1, 0,1,0,0,0);
        add(1,0,0,1, 0,1,0,0,0);
        add(1,0,0,1, 1,1,1,0,0);
        add(1,0,0,1, 1,1,0,0,0);
        add(1,0,0,1, 1,1,0,0,0);
        cfg(2'd2, 2'd0, 2'd3, 8'd1, 1'b0, 1'b0);
        add(1,0,0,1, 2,1,1,0,0);
        add(1,0,1,0, 2,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            cfg_mode = vecs[i].mode; cfg_first = vecs[i].first; cfg_last = vecs[i].last;
            cfg_dwell = vecs[i].dwell; cfg_mirror = vecs[i].mir; cfg_tog = vecs[i].tog;
            enable = vecs[i].en; start = vecs[i].start; stop = vecs[i].stop;
            scan_wrap = vecs[i].wrap;
            tick();
            chk_all($sformatf("row%0d", i), vecs[i].e_frame, vecs[i].e_busy,
                    vecs[i].e_adv, vecs[i].e_done, vecs[i].e_mir);
        end
        start = 0; stop = 0; scan_wrap = 0; enable = 1;

        // F: reset mid-run after a mirror toggle
        cfg_mode = 2'd2; cfg_first = 2'd0; cfg_last = 2'd3; cfg_dwell = 8'd0;
        cfg_mirror = 1; cfg_tog = 1;
        start = 1;
        tick();
        start = 0;
        chk_all("f_start", 0, 1, 0, 0, 1);
        scan_wrap = 1;
        for (int k = 0; k < 6; k++) tick();
        scan_wrap = 0;
        chk_all("f_pre_reset", 2, 1, 1, 0, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk_all("f_reset", 0, 0, 0, 0, 1);
        scan_wrap = 1;
        tick();
        scan_wrap = 0;
        chk_all("f_idle_after_reset", 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
